// File: rtl/mac_isa_encoder.sv
// Packs ctrl/opa/opb into tagged 32-bit words queued in a DEPTH-entry FIFO; head visible the cycle after a push.
// Backpressure: in_ready drops when full or flushing; en=0 hides the head and blocks pops. Option: ISA_ENC_CHECKSUM_EN.
module mac_isa_encoder #(
   parameter int DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_ctrl,
   input  logic [7:0]               in_opa,
   input  logic [7:0]               in_opb,
   output logic [31:0]              instr_out,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [3:0]       seq;
   logic [3:0]       chk;
   logic [31:0]      word;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Pointers carry one extra MSB so full and empty are distinguishable when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign in_ready    = rst & ~full & ~flush;
   assign push        = in_valid & in_ready;
   assign instr_valid = en & ~empty;
   assign pop         = instr_valid & instr_ready;
   assign fifo_count  = CNT_W'(wr_ptr - rd_ptr);
   assign instr_out   = empty ? 32'h0 : mem[rd_ptr[PTR_W-1:0]];

`ifdef ISA_ENC_CHECKSUM_EN
   assign chk = in_ctrl[7:4] ^ in_ctrl[3:0] ^ in_opa[7:4] ^ in_opa[3:0] ^
                in_opb[7:4] ^ in_opb[3:0] ^ seq;
`else
   assign chk = 4'h0;
`endif

   assign word = {in_ctrl, in_opa, in_opb, seq, chk};

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         seq    <= 4'h0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 32'h0;
         end
      end else if (flush) begin
         // Flush wins over any push or pop presented on the same edge.
         wr_ptr <= '0;
         rd_ptr <= '0;
         seq    <= 4'h0;
      end else begin
         if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= word;
            wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
            seq                    <= seq + 4'h1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

endmodule
